// File: rtl/prog_loader.sv
// Boot/run sequencer: holds the CPU in reset, streams a host program into
// instruction memory, then releases the CPU, pulses start and holds enable.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              i_we,
  output logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_dataout,
  output logic              cpu_rst,
  output logic              cpu_start,
  output logic              cpu_enable,
  output logic              busy,
  output logic              running,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REL,
    S_START,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic              r_err;

  logic w_idle;
  logic w_load;
  logic w_len_ok;
  logic w_start_ld;
  logic w_bad_ld;
  logic w_hs;
  logic w_last;
  logic w_abort;

  assign w_idle     = (r_state == S_IDLE);
  assign w_load     = (r_state == S_LOAD);
  assign w_len_ok   = (load_len != '0) && (load_len <= MAX_LEN);
  assign w_start_ld = w_idle & load_req & w_len_ok;
  assign w_bad_ld   = w_idle & load_req & ~w_len_ok;
  assign w_hs       = w_load & s_valid & ~abort;
  assign w_last     = w_hs & (r_rem == ONE_LEN);
  assign w_abort    = w_load & abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (load_req) begin
          if (w_len_ok) w_next = S_LOAD;
        end else if (run_req) begin
          w_next = S_REL;
        end
      end
      S_LOAD: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_REL;
      end
      S_REL:   w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (halt_req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_bad_ld | w_abort;
      if (w_start_ld) begin
        r_addr <= '0;
        r_rem  <= load_len;
      end else if (w_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - ONE_LEN;
      end
    end
  end

  always_comb begin
    s_ready    = 1'b0;
    cpu_rst    = 1'b0;
    cpu_start  = 1'b0;
    cpu_enable = 1'b0;
    busy       = 1'b0;
    running    = 1'b0;
    unique case (r_state)
      S_IDLE: cpu_rst = 1'b1;
      S_LOAD: begin
        s_ready = 1'b1;
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      S_REL: busy = 1'b1;
      S_START: begin
        cpu_start  = 1'b1;
        cpu_enable = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        cpu_enable = 1'b1;
        running    = 1'b1;
      end
      default: cpu_rst = 1'b1;
    endcase
  end

  // memory write port is a straight pass-through of the accepted beat
  assign i_we      = w_hs;
  assign i_addr    = r_addr;
  assign i_dataout = w_load ? s_data : '0;
  assign err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued
// as words are offered and retired by a write-port monitor.
module tb_prog_loader;

  localparam int AW = 8;
  localparam int DW = 16;

  localparam logic [7:0] C_IDLE  = 8'b0010_0000;
  localparam logic [7:0] C_ERR   = 8'b0010_0001;
  localparam logic [7:0] C_LDWR  = 8'b1110_0100;
  localparam logic [7:0] C_REL   = 8'b0000_0100;
  localparam logic [7:0] C_START = 8'b0001_1100;
  localparam logic [7:0] C_RUN   = 8'b0000_1010;
  localparam logic [7:0] C_LDAB  = 8'b1010_0100;

  logic          clk;
  logic          rst;
  logic          load_req;
  logic [AW:0]   load_len;
  logic          run_req;
  logic          halt_req;
  logic          abort;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_dataout;
  logic          cpu_rst;
  logic          cpu_start;
  logic          cpu_enable;
  logic          busy;
  logic          running;
  logic          err;

  logic [7:0] ctl;
  assign ctl = {s_ready, i_we, cpu_rst, cpu_start,
                cpu_enable, busy, running, err};

  int n_vec = 0;
  int n_bad = 0;
  logic [AW+DW-1:0] sb[$];

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_len   (load_len),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_dataout  (i_dataout),
    .cpu_rst    (cpu_rst),
    .cpu_start  (cpu_start),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .running    (running),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (i_we) begin
      logic [AW+DW-1:0] e;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected addr=%h data=%h want no write",
                 i_addr, i_dataout);
      end else begin
        e = sb.pop_front();
        if ({i_addr, i_dataout} !== e) begin
          n_bad++;
          $display("FAIL wr_data got=%h want=%h",
                   {i_addr, i_dataout}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_req = 0; load_len = '0; run_req = 0;
    halt_req = 0; abort = 0; s_valid = 0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE || i_addr !== '0 || i_dataout !== '0) begin
      n_bad++;
      $display("FAIL reset ctl=%b addr=%h data=%h want ctl=%b 0 0",
               ctl, i_addr, i_dataout, C_IDLE);
    end
    rst = 1'b1;
  endtask

  task automatic test_load4();
    logic [DW-1:0] d;
    tick();
    load_req = 1; load_len = 9'd4;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL l4_req ctl=%b want=%b", ctl, C_IDLE);
    end
    tick();
    load_req = 0;
    for (int i = 0; i < 4; i++) begin
      d = 16'(16'h1111 * (i + 1));
      s_valid = 1; s_data = d;
      sb.push_back({8'(i), d});
      @(negedge clk);
      n_vec++;
      if (ctl !== C_LDWR) begin
        n_bad++;
        $display("FAIL l4_load ctl=%b want=%b", ctl, C_LDWR);
      end
      tick();
    end
    s_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_REL) begin
      n_bad++;
      $display("FAIL l4_rel ctl=%b want=%b", ctl, C_REL);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_START) begin
      n_bad++;
      $display("FAIL l4_start ctl=%b want=%b", ctl, C_START);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL l4_run ctl=%b want=%b", ctl, C_RUN);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE || sb.size() != 0) begin
      n_bad++;
      $display("FAIL l4_halt ctl=%b left=%0d want=%b 0",
               ctl, sb.size(), C_IDLE);
    end
  endtask

  task automatic test_toggle();
    logic [5:0] pat;
    logic [DW-1:0] d;
    int k;
    pat = 6'b101001;
    k = 0;
    tick();
    load_req = 1; run_req = 1; load_len = 9'd3;
    tick();
    load_req = 0; run_req = 0;
    for (int j = 0; j < 6; j++) begin
      d = 16'(16'hB000 + j);
      s_valid = pat[j]; s_data = d;
      if (pat[j]) begin
        sb.push_back({8'(k), d});
        k++;
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || i_we !== pat[j]) begin
        n_bad++;
        $display("FAIL tog_%0d busy=%b rdy=%b we=%b want 1 1 %b",
                 j, busy, s_ready, i_we, pat[j]);
      end
      tick();
    end
    s_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_REL) begin
      n_bad++;
      $display("FAIL tog_rel ctl=%b want=%b", ctl, C_REL);
    end
    tick();
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL tog_run ctl=%b want=%b", ctl, C_RUN);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE || sb.size() != 0) begin
      n_bad++;
      $display("FAIL tog_halt ctl=%b left=%0d want=%b 0",
               ctl, sb.size(), C_IDLE);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    tick();
    load_req = 1; load_len = 9'd256;
    tick();
    load_req = 0;
    for (int i = 0; i < 256; i++) begin
      d = 16'(16'h5A00 + i * 3);
      s_valid = 1; s_data = d;
      sb.push_back({8'(i), d});
      tick();
    end
    s_data = 16'hDEAD;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_REL || sb.size() != 0) begin
      n_bad++;
      $display("FAIL full_rel ctl=%b left=%0d want=%b 0",
               ctl, sb.size(), C_REL);
    end
    tick();
    s_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_START) begin
      n_bad++;
      $display("FAIL full_start ctl=%b want=%b", ctl, C_START);
    end
    halt_req = 1;
    tick();
    tick();
    halt_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL full_halt ctl=%b want=%b", ctl, C_IDLE);
    end
  endtask

  task automatic test_abort();
    tick();
    load_req = 1; load_len = 9'd2;
    tick();
    load_req = 0;
    s_valid = 1; s_data = 16'hC0DE;
    sb.push_back({8'h00, 16'hC0DE});
    tick();
    s_data = 16'hBAD0; abort = 1;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_LDAB) begin
      n_bad++;
      $display("FAIL ab_cycle ctl=%b want=%b", ctl, C_LDAB);
    end
    tick();
    abort = 0; s_valid = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_ERR) begin
      n_bad++;
      $display("FAIL ab_err ctl=%b want=%b", ctl, C_ERR);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_vec++;
      if (ctl !== C_IDLE) begin
        n_bad++;
        $display("FAIL ab_idle%0d ctl=%b want=%b", i, ctl, C_IDLE);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL ab_sb left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_len0_run();
    tick();
    load_req = 1; load_len = 9'd0;
    tick();
    load_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_ERR) begin
      n_bad++;
      $display("FAIL len0_err ctl=%b want=%b", ctl, C_ERR);
    end
    tick();
    load_req = 1; load_len = 9'd257;
    tick();
    load_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_ERR) begin
      n_bad++;
      $display("FAIL len257_err ctl=%b want=%b", ctl, C_ERR);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL len_clr ctl=%b want=%b", ctl, C_IDLE);
    end
    run_req = 1;
    tick();
    run_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_REL) begin
      n_bad++;
      $display("FAIL run_rel ctl=%b want=%b", ctl, C_REL);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_START) begin
      n_bad++;
      $display("FAIL run_start ctl=%b want=%b", ctl, C_START);
    end
    tick();
    load_req = 1; run_req = 1; load_len = 9'd4;
    tick();
    load_req = 0; run_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL run_ignore ctl=%b want=%b", ctl, C_RUN);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL run_halt ctl=%b want=%b", ctl, C_IDLE);
    end
  endtask

  task automatic test_reset_midload();
    logic [DW-1:0] d;
    tick();
    load_req = 1; load_len = 9'd8;
    tick();
    load_req = 0;
    for (int i = 0; i < 3; i++) begin
      d = 16'(16'h7700 + i);
      s_valid = 1; s_data = d;
      sb.push_back({8'(i), d});
      tick();
    end
    s_data = 16'hEEEE;
    rst = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_IDLE || i_addr !== '0 || i_dataout !== '0) begin
      n_bad++;
      $display("FAIL rst_mid ctl=%b addr=%h data=%h want=%b 0 0",
               ctl, i_addr, i_dataout, C_IDLE);
    end
    s_valid = 0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== C_IDLE || sb.size() != 0) begin
      n_bad++;
      $display("FAIL rst_after ctl=%b left=%0d want=%b 0",
               ctl, sb.size(), C_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_toggle();
    test_full();
    test_abort();
    test_len0_run();
    test_reset_midload();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
